// File: rtl/parking_log_controller.sv
`default_nettype none
// ============================================================================
// Module      : parking_log_controller
// Description : Sequencer for the parking-lot logging RAM (8 x CNT_W).
//               RECORD/COMMIT phase: counts arriving cars (saturating) and
//               writes the running total into RAM word N at the end of
//               hour N. After word 7 is committed, the read port sweeps
//               addresses 0..7..0, showing one logged word per display tick.
//               Then it parks in FINISHED until replay or reset.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               car_enter         - one pulse per arriving car
//               hour_tick         - end-of-hour pulse
//               disp_tick         - playback advance pulse (used in HOLD only)
//               replay            - restart playback from FINISHED
//               ram_q             - RAM read data (RD_LAT clocks after addr)
//               ram_wren/_wraddr/_wdata - RAM write port
//               ram_rdaddr        - RAM read address
//               car_total         - running car count
//               hour_count        - hour currently being recorded
//               disp_valid        - one-cycle pulse when disp_* update
//               disp_addr/_data   - word currently shown
//               playing, done     - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module parking_log_controller #(
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             car_enter,
    input  logic             hour_tick,
    input  logic             disp_tick,
    input  logic             replay,
    input  logic [CNT_W-1:0] ram_q,
    output logic             ram_wren,
    output logic [2:0]       ram_wraddr,
    output logic [CNT_W-1:0] ram_wdata,
    output logic [2:0]       ram_rdaddr,
    output logic [CNT_W-1:0] car_total,
    output logic [2:0]       hour_count,
    output logic             disp_valid,
    output logic [2:0]       disp_addr,
    output logic [CNT_W-1:0] disp_data,
    output logic             playing,
    output logic             done
);

    localparam logic [2:0] c_ST_RECORD   = 3'd0;
    localparam logic [2:0] c_ST_COMMIT   = 3'd1;
    localparam logic [2:0] c_ST_PLAYBACK = 3'd2;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_HOLD     = 3'd4;
    localparam logic [2:0] c_ST_FINISHED = 3'd5;

    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [3:0]       c_SWEEP_LAST = 4'd14;
    localparam logic [2:0]       c_LAST_HOUR  = 3'd7;
    localparam logic [1:0]       c_RD_LAT     = 2'(RD_LAT);

    // Sweep position 0..14 maps to address 0..7 going up, then 6..0 down.
    function automatic logic [2:0] f_sweep_addr(input logic [3:0] idx);
        if (idx <= 4'd7) begin
            return idx[2:0];
        end
        return 3'(c_SWEEP_LAST - idx);
    endfunction

    logic [2:0]       r_state,      w_state_next;
    logic [CNT_W-1:0] r_car_total,  w_car_total_next;
    logic [2:0]       r_hour_count, w_hour_count_next;
    logic             r_pending,    w_pending_next;
    logic [3:0]       r_sweep_idx,  w_sweep_idx_next;
    logic [1:0]       r_lat_cnt,    w_lat_cnt_next;
    logic [2:0]       r_rdaddr,     w_rdaddr_next;
    logic             r_wren,       w_wren_next;
    logic [2:0]       r_wraddr,     w_wraddr_next;
    logic [CNT_W-1:0] r_wdata,      w_wdata_next;
    logic             r_disp_valid, w_disp_valid_next;
    logic [2:0]       r_disp_addr,  w_disp_addr_next;
    logic [CNT_W-1:0] r_disp_data,  w_disp_data_next;
    logic             r_playing;
    logic             r_done;
    logic             w_counting;
    logic [3:0]       w_sweep_inc;

    assign w_counting  = (r_state == c_ST_RECORD) || (r_state == c_ST_COMMIT);
    assign w_sweep_inc = r_sweep_idx + 4'd1;

    always_comb begin
        w_state_next      = r_state;
        w_car_total_next  = r_car_total;
        w_hour_count_next = r_hour_count;
        w_pending_next    = r_pending;
        w_sweep_idx_next  = r_sweep_idx;
        w_lat_cnt_next    = r_lat_cnt;
        w_rdaddr_next     = r_rdaddr;
        w_wren_next       = 1'b0;
        w_wraddr_next     = r_wraddr;
        w_wdata_next      = r_wdata;
        w_disp_valid_next = 1'b0;
        w_disp_addr_next  = r_disp_addr;
        w_disp_data_next  = r_disp_data;

        if (car_enter && w_counting && (r_car_total != c_CNT_MAX)) begin
            w_car_total_next = r_car_total + 1'b1;
        end

        case (r_state)
            c_ST_RECORD: begin
                // Write strobe is registered so it lines up with the COMMIT
                // cycle; the data already includes a same-cycle car.
                if (hour_tick) begin
                    w_state_next  = c_ST_COMMIT;
                    w_wren_next   = 1'b1;
                    w_wraddr_next = r_hour_count;
                    w_wdata_next  = w_car_total_next;
                end
            end

            c_ST_COMMIT: begin
                w_hour_count_next = r_hour_count + 3'd1;
                if (r_hour_count == c_LAST_HOUR) begin
                    w_state_next     = c_ST_PLAYBACK;
                    w_sweep_idx_next = 4'd0;
                    w_rdaddr_next    = 3'd0;
                end else if (r_pending || hour_tick) begin
                    // Back-to-back tick: the next hour commits immediately.
                    w_state_next   = c_ST_COMMIT;
                    w_pending_next = 1'b0;
                    w_wren_next    = 1'b1;
                    w_wraddr_next  = r_hour_count + 3'd1;
                    w_wdata_next   = w_car_total_next;
                end else begin
                    w_state_next = c_ST_RECORD;
                end
            end

            c_ST_PLAYBACK: begin
                // Read address was already launched on entry, so the RAM
                // latency overlaps this cycle.
                w_rdaddr_next  = f_sweep_addr(r_sweep_idx);
                w_lat_cnt_next = 2'd1;
                w_state_next   = c_ST_RD_WAIT;
            end

            c_ST_RD_WAIT: begin
                if (r_lat_cnt == c_RD_LAT) begin
                    w_disp_valid_next = 1'b1;
                    w_disp_data_next  = ram_q;
                    w_disp_addr_next  = r_rdaddr;
                    w_state_next      = c_ST_HOLD;
                end else begin
                    w_lat_cnt_next = r_lat_cnt + 2'd1;
                end
            end

            c_ST_HOLD: begin
                if (disp_tick) begin
                    if (r_sweep_idx == c_SWEEP_LAST) begin
                        w_state_next = c_ST_FINISHED;
                    end else begin
                        w_sweep_idx_next = w_sweep_inc;
                        w_rdaddr_next    = f_sweep_addr(w_sweep_inc);
                        w_state_next     = c_ST_PLAYBACK;
                    end
                end
            end

            c_ST_FINISHED: begin
                if (replay) begin
                    w_sweep_idx_next = 4'd0;
                    w_rdaddr_next    = 3'd0;
                    w_state_next     = c_ST_PLAYBACK;
                end
            end

            default: begin
                w_state_next = c_ST_RECORD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_RECORD;
            r_car_total  <= '0;
            r_hour_count <= 3'd0;
            r_pending    <= 1'b0;
            r_sweep_idx  <= 4'd0;
            r_lat_cnt    <= 2'd0;
            r_rdaddr     <= 3'd0;
            r_wren       <= 1'b0;
            r_wraddr     <= 3'd0;
            r_wdata      <= '0;
            r_disp_valid <= 1'b0;
            r_disp_addr  <= 3'd0;
            r_disp_data  <= '0;
            r_playing    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_car_total  <= w_car_total_next;
            r_hour_count <= w_hour_count_next;
            r_pending    <= w_pending_next;
            r_sweep_idx  <= w_sweep_idx_next;
            r_lat_cnt    <= w_lat_cnt_next;
            r_rdaddr     <= w_rdaddr_next;
            r_wren       <= w_wren_next;
            r_wraddr     <= w_wraddr_next;
            r_wdata      <= w_wdata_next;
            r_disp_valid <= w_disp_valid_next;
            r_disp_addr  <= w_disp_addr_next;
            r_disp_data  <= w_disp_data_next;
            r_playing    <= (w_state_next == c_ST_PLAYBACK) ||
                            (w_state_next == c_ST_RD_WAIT)  ||
                            (w_state_next == c_ST_HOLD);
            r_done       <= (w_state_next == c_ST_FINISHED);
        end
    end

    assign ram_wren   = r_wren;
    assign ram_wraddr = r_wraddr;
    assign ram_wdata  = r_wdata;
    assign ram_rdaddr = r_rdaddr;
    assign car_total  = r_car_total;
    assign hour_count = r_hour_count;
    assign disp_valid = r_disp_valid;
    assign disp_addr  = r_disp_addr;
    assign disp_data  = r_disp_data;
    assign playing    = r_playing;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_parking_log_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_log_controller
// Description : Self-checking bench for parking_log_controller with a
//               behavioural RAM (RD_LAT read pipeline) and a reference model
//               of the daily log (car total, per-hour words, sweep order).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_log_controller;

    localparam int RD_LAT = 2;
    localparam int CNT_W  = 16;
    localparam int MAX_CNT = 65535;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             car_enter = 1'b0;
    logic             hour_tick = 1'b0;
    logic             disp_tick = 1'b0;
    logic             replay = 1'b0;
    logic [CNT_W-1:0] ram_q;
    logic             ram_wren;
    logic [2:0]       ram_wraddr;
    logic [CNT_W-1:0] ram_wdata;
    logic [2:0]       ram_rdaddr;
    logic [CNT_W-1:0] car_total;
    logic [2:0]       hour_count;
    logic             disp_valid;
    logic [2:0]       disp_addr;
    logic [CNT_W-1:0] disp_data;
    logic             playing;
    logic             done;

    parking_log_controller #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .car_enter  (car_enter),
        .hour_tick  (hour_tick),
        .disp_tick  (disp_tick),
        .replay     (replay),
        .ram_q      (ram_q),
        .ram_wren   (ram_wren),
        .ram_wraddr (ram_wraddr),
        .ram_wdata  (ram_wdata),
        .ram_rdaddr (ram_rdaddr),
        .car_total  (car_total),
        .hour_count (hour_count),
        .disp_valid (disp_valid),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .playing    (playing),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Behavioural RAM: read data appears RD_LAT clocks after the address.
    logic [CNT_W-1:0] ram_mem  [8];
    logic [CNT_W-1:0] ram_pipe [RD_LAT];
    int               wr_count [8];

    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_wraddr] <= ram_wdata;
        ram_pipe[0] <= ram_mem[ram_rdaddr];
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_q = ram_pipe[RD_LAT-1];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) wr_count[i] <= 0;
        end else if (ram_wren) begin
            wr_count[ram_wraddr] <= wr_count[ram_wraddr] + 1;
        end
    end

    // Reference model state
    int checks   = 0;
    int failures = 0;
    int exp_total;
    int exp_hour;
    int exp_log [8];
    int sweep_q [$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_car();
        if (exp_total < MAX_CNT) exp_total++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " car_total"},  car_total,  0);
        check({tag, " hour_count"}, hour_count, 0);
        check({tag, " disp_addr"},  disp_addr,  0);
        check({tag, " disp_data"},  disp_data,  0);
        check({tag, " ram_rdaddr"}, ram_rdaddr, 0);
        check({tag, " ram_wraddr"}, ram_wraddr, 0);
        check({tag, " ram_wdata"},  ram_wdata,  0);
        check({tag, " ram_wren"},   ram_wren,   0);
        check({tag, " disp_valid"}, disp_valid, 0);
        check({tag, " playing"},    playing,    0);
        check({tag, " done"},       done,       0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_zero(tag);
        exp_total = 0;
        exp_hour  = 0;
    endtask

    // One logged hour: n_cars, optional car on the tick cycle, optional car
    // during COMMIT, optional back-to-back tick committing the next hour too.
    task automatic run_hour(input int n_cars, input bit car_on_tick,
                            input bit car_in_commit, input bit b2b);
        int last;
        for (int i = 0; i < n_cars; i++) begin
            car_enter = 1'b1;
            tick();
            car_enter = 1'b0;
            add_car();
            repeat ($urandom_range(0, 2)) tick();
        end
        car_enter = car_on_tick;
        hour_tick = 1'b1;
        tick();
        car_enter = 1'b0;
        hour_tick = 1'b0;
        if (car_on_tick) add_car();
        exp_log[exp_hour] = exp_total;
        check("commit wren",   ram_wren,   1);
        check("commit wraddr", ram_wraddr, exp_hour);
        check("commit wdata",  ram_wdata,  exp_total);
        last     = exp_hour;
        exp_hour = (exp_hour + 1) % 8;
        hour_tick = b2b;
        car_enter = car_in_commit;
        tick();
        hour_tick = 1'b0;
        car_enter = 1'b0;
        if (car_in_commit) add_car();
        if (b2b) begin
            exp_log[exp_hour] = exp_total;
            check("b2b wren",   ram_wren,   1);
            check("b2b wraddr", ram_wraddr, exp_hour);
            check("b2b wdata",  ram_wdata,  exp_total);
            last     = exp_hour;
            exp_hour = (exp_hour + 1) % 8;
            tick();
        end
        check("hour_count", hour_count, exp_hour);
        check("car_total",  car_total,  exp_total);
        check("wren after commit", ram_wren, 0);
        check("playing after commit", playing, (last == 7));
        check("disp_valid after commit", disp_valid, 0);
    endtask

    // Wait for disp_valid while injecting ignored disp_tick/car_enter noise.
    task automatic wait_display(output int lat);
        lat = 0;
        do begin
            disp_tick = 1'($urandom_range(0, 1));
            car_enter = 1'($urandom_range(0, 1));
            tick();
            lat++;
            disp_tick = 1'b0;
            car_enter = 1'b0;
        end while (!disp_valid && lat < 20);
    endtask

    // Starts in the first PLAYBACK cycle; ends in FINISHED.
    task automatic play_sweep(input string tag);
        int lat;
        for (int k = 0; k < sweep_q.size(); k++) begin
            if (k != 0) begin
                disp_tick = 1'b1;
                tick();
                disp_tick = 1'b0;
            end
            wait_display(lat);
            check({tag, " latency"},   lat,       RD_LAT + 1);
            check({tag, " disp_addr"}, disp_addr, sweep_q[k]);
            check({tag, " disp_data"}, disp_data, exp_log[sweep_q[k]]);
            check({tag, " playing"},   playing,   1);
            repeat ($urandom_range(1, 3)) begin
                car_enter = 1'($urandom_range(0, 1));
                hour_tick = 1'($urandom_range(0, 1));
                tick();
                car_enter = 1'b0;
                hour_tick = 1'b0;
                check({tag, " hold disp_valid"}, disp_valid, 0);
                check({tag, " hold disp_addr"},  disp_addr,  sweep_q[k]);
            end
        end
        disp_tick = 1'b1;
        tick();
        disp_tick = 1'b0;
        check({tag, " done"},       done,       1);
        check({tag, " playing end"}, playing,   0);
        check({tag, " last addr"},  disp_addr,  0);
        check({tag, " last data"},  disp_data,  exp_log[0]);
        check({tag, " rdaddr end"}, ram_rdaddr, 0);
        check({tag, " total held"}, car_total,  exp_total);
        check({tag, " hour end"},   hour_count, 0);
    endtask

    task automatic check_writes_once(input string tag);
        for (int a = 0; a < 8; a++) check({tag, " write count"}, wr_count[a], 1);
    endtask

    initial begin
        for (int a = 0; a < 8; a++) sweep_q.push_back(a);
        for (int a = 6; a >= 0; a--) sweep_q.push_back(a);

        // Day 1: directed first hours then random traffic.
        do_reset("reset");
        run_hour(3, 1'b0, 1'b0, 1'b0);
        run_hour(1, 1'b1, 1'b1, 1'b0);
        check("logged hour1", exp_log[1], 5);
        run_hour($urandom_range(0, 4), 1'b0, 1'b0, 1'b1);
        for (int h = 4; h < 8; h++) begin
            run_hour($urandom_range(0, 6), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
        end
        check_writes_once("day1");
        play_sweep("day1");

        // FINISHED ignores hour_tick and car_enter; replay repeats the sweep.
        repeat (3) begin
            hour_tick = 1'b1;
            car_enter = 1'b1;
            tick();
            hour_tick = 1'b0;
            car_enter = 1'b0;
            check("finished done", done, 1);
            check("finished wren", ram_wren, 0);
            check("finished hour", hour_count, 0);
            check("finished total", car_total, exp_total);
        end
        replay = 1'b1;
        tick();
        replay = 1'b0;
        play_sweep("replay");

        // Day 2: totals 1..8.
        do_reset("reset day2");
        for (int h = 0; h < 8; h++) run_hour(1, 1'b0, 1'b0, 1'b0);
        check_writes_once("day2");
        play_sweep("day2");

        // Saturation.
        do_reset("reset sat");
        car_enter = 1'b1;
        repeat (65535) tick();
        check("sat reach", car_total, 16'hFFFF);
        tick();
        car_enter = 1'b0;
        check("sat hold", car_total, 16'hFFFF);
        exp_total = MAX_CNT;
        for (int h = 0; h < 8; h++) run_hour(0, 1'b0, 1'b0, 1'b0);

        // Reset in RD_WAIT.
        tick();
        check("rd_wait playing", playing, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("rst rd_wait");

        // Reset during COMMIT.
        hour_tick = 1'b1;
        tick();
        hour_tick = 1'b0;
        check("pre-reset commit wren", ram_wren, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("rst commit");
        tick();
        check("post reset wren", ram_wren, 0);
        check("post reset hour", hour_count, 0);
        check("post reset playing", playing, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
